// File: rtl/ram_access_ctrl_pkg.sv
// Shared types for the RAM access sequencer.
// Holds the FSM state encoding and the default bus widths.
package ram_access_ctrl_pkg;

  localparam int AW_DEF = 16;
  localparam int DW_DEF = 16;
  localparam int LW_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_STROBE   = 3'd1,
    ST_CAPTURE  = 3'd2,
    ST_WAIT_RSP = 3'd3,
    ST_RECOVER  = 3'd4
  } state_t;

endpackage

// File: rtl/ram_access_ctrl_if.sv
// Command/response handshake bundle for ram_access_ctrl.
// master = command issuer / response consumer, slave = controller.
interface ram_access_ctrl_if
  import ram_access_ctrl_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF,
  parameter int LW = LW_DEF
);

  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_wr;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [LW-1:0] cmd_len;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          rsp_last;
  logic          wr_done;

  modport master (
    output cmd_valid, cmd_wr, cmd_addr,
    output cmd_wdata, cmd_len, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data,
    input  rsp_last, wr_done
  );

  modport slave (
    input  cmd_valid, cmd_wr, cmd_addr,
    input  cmd_wdata, cmd_len, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data,
    output rsp_last, wr_done
  );

endinterface

// File: rtl/ram_access_ctrl_rsp_reg.sv
// Read-response holding register: data + last flag + valid.
// load has priority over clear; otherwise contents hold.
module ram_access_ctrl_rsp_reg #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          clear,
  input  logic [DW-1:0] d_data,
  input  logic          d_last,
  output logic [DW-1:0] q_data,
  output logic          q_last,
  output logic          q_valid
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_data  <= '0;
      q_last  <= 1'b0;
      q_valid <= 1'b0;
    end else if (load) begin
      q_data  <= d_data;
      q_last  <= d_last;
      q_valid <= 1'b1;
    end else if (clear) begin
      q_data  <= '0;
      q_last  <= 1'b0;
      q_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/ram_access_ctrl.sv
// Single-port RAM command sequencer: strobe, capture, recover.
// RAM_ACC_BURST_EN enables multi-beat reads via cmd_len.
module ram_access_ctrl
  import ram_access_ctrl_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF,
  parameter int LW = LW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  ram_access_ctrl_if.slave bus,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_data_in,
  input  logic [DW-1:0] ram_data_out,
  output logic          ram_rd,
  output logic          ram_wr,
  output logic          ram_cs
);

  state_t state, state_n;
  logic   wr_q, wr_nx, accept;
  logic   load, clear, more, last;
  logic   cs_nx, wr_done_q;

  assign bus.cmd_ready = rst_n && (state == ST_IDLE);
  assign accept = bus.cmd_valid && bus.cmd_ready;
  assign wr_nx  = (state == ST_IDLE) ? bus.cmd_wr : wr_q;
  assign bus.wr_done = wr_done_q;

`ifdef RAM_ACC_BURST_EN
  logic [LW-1:0] beats_q;

  assign more = (beats_q != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      beats_q <= '0;
    else if (accept)
      beats_q <= bus.cmd_len;
    else if (clear && more)
      beats_q <= beats_q - 1'b1;
  end
`else
  logic unused_len;

  assign unused_len = ^bus.cmd_len;
  assign more = 1'b0;
`endif

  assign last = !more;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= ST_IDLE;
    else
      state <= state_n;
  end

  always_comb begin
    state_n = state;
    load    = 1'b0;
    clear   = 1'b0;
    unique case (state)
      ST_IDLE:
        if (accept) state_n = ST_STROBE;
      ST_STROBE:
        state_n = wr_q ? ST_RECOVER : ST_CAPTURE;
      ST_CAPTURE: begin
        load    = 1'b1;
        state_n = ST_WAIT_RSP;
      end
      ST_WAIT_RSP:
        if (bus.rsp_ready) begin
          clear   = 1'b1;
          state_n = more ? ST_STROBE : ST_RECOVER;
        end
      ST_RECOVER:
        state_n = ST_IDLE;
      default:
        state_n = ST_IDLE;
    endcase
  end

  // Address only moves on accept or between beats, both with CS low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q        <= 1'b0;
      ram_addr    <= '0;
      ram_data_in <= '0;
    end else if (accept) begin
      wr_q        <= bus.cmd_wr;
      ram_addr    <= bus.cmd_addr;
      ram_data_in <= bus.cmd_wdata;
    end else if (clear && more) begin
      ram_addr    <= ram_addr + 1'b1;
    end
  end

  assign cs_nx = (state_n == ST_STROBE) ||
                 (state_n == ST_CAPTURE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_cs    <= 1'b0;
      ram_rd    <= 1'b0;
      ram_wr    <= 1'b0;
      wr_done_q <= 1'b0;
    end else begin
      ram_cs    <= cs_nx;
      ram_rd    <= cs_nx && !wr_nx;
      ram_wr    <= (state_n == ST_STROBE) && wr_nx;
      wr_done_q <= (state_n == ST_RECOVER) && wr_q;
    end
  end

  ram_access_ctrl_rsp_reg #(.DW(DW)) u_rsp (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .clear   (clear),
    .d_data  (ram_data_out),
    .d_last  (last),
    .q_data  (bus.rsp_data),
    .q_last  (bus.rsp_last),
    .q_valid (bus.rsp_valid)
  );

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Scoreboard bench for ram_access_ctrl with a 1024-word RAM model.
// Build with +define+RAM_ACC_BURST_EN to exercise burst reads.
module tb_ram_access_ctrl;
  import ram_access_ctrl_pkg::*;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int LW = 8;
  localparam int MW = 1024;
`ifdef RAM_ACC_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram_access_ctrl_if bus ();

  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data_in;
  logic [DW-1:0] ram_data_out = '0;
  logic          ram_rd, ram_wr, ram_cs;

  ram_access_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .ram_addr     (ram_addr),
    .ram_data_in  (ram_data_in),
    .ram_data_out (ram_data_out),
    .ram_rd       (ram_rd),
    .ram_wr       (ram_wr),
    .ram_cs       (ram_cs)
  );

  logic [DW-1:0] mem [MW];

  always @(posedge clk) begin
    if (ram_cs && ram_wr) mem[ram_addr[9:0]] <= ram_data_in;
    if (ram_cs && ram_rd) ram_data_out <= mem[ram_addr[9:0]];
  end

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } rsp_t;

  rsp_t          exp_q[$];
  logic [AW-1:0] addr_log[$];
  logic [DW-1:0] ref_mem [MW];
  int compared = 0;
  int mismatched = 0;
  int rr_mode = 1;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void push_read(input logic [AW-1:0] addr,
                                    input logic [LW-1:0] len);
    int beats;
    logic [AW-1:0] a;
    beats = BURST ? int'(len) + 1 : 1;
    for (int i = 0; i < beats; i++) begin
      a = addr + AW'(i);
      exp_q.push_back({ref_mem[int'(a) % MW], i == beats - 1});
    end
  endfunction

  always @(posedge clk) begin
    #2;
    case (rr_mode)
      0:       bus.rsp_ready = ($urandom % 3) != 0;
      1:       bus.rsp_ready = 1'b1;
      default: bus.rsp_ready = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    rsp_t e;
    if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_rsp: got %h expected none",
                 bus.rsp_data);
      end else begin
        e = exp_q.pop_front();
        check("rsp_data", 32'(bus.rsp_data), 32'(e.data));
        check("rsp_last", 32'(bus.rsp_last), 32'(e.last));
      end
    end
  end

  logic          prev_cs = 1'b0;
  logic [AW-1:0] prev_addr = '0;

  always @(negedge clk) begin
    if (rst_n) begin
      check("rd_wr_excl", 32'(ram_rd && ram_wr), 0);
      if (ram_addr != prev_addr)
        check("addr_move_cs", 32'(prev_cs), 0);
      if (ram_cs && ram_rd && !prev_cs)
        addr_log.push_back(ram_addr);
    end
    prev_cs   = ram_cs;
    prev_addr = ram_addr;
  end

  task automatic send_cmd(input logic          wr,
                          input logic [AW-1:0] addr,
                          input logic [DW-1:0] wd,
                          input logic [LW-1:0] len);
    int n = 0;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_wr    = wr;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wd;
    bus.cmd_len   = len;
    while (!bus.cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      compared++;
      mismatched++;
      $display("FAIL cmd_timeout: got ready=0 expected ready=1");
      bus.cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    if (wr) ref_mem[int'(addr) % MW] = wd;
    else push_read(addr, len);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || bus.rsp_valid ||
            !bus.cmd_ready) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", 32'(exp_q.size()), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] hold_d;
    logic [DW-1:0] v;
    for (int i = 0; i < MW; i++) begin
      mem[i]     = '0;
      ref_mem[i] = '0;
    end
    bus.cmd_valid = 1'b0;
    bus.cmd_wr    = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.cmd_len   = '0;

    #12;
    check("rst_ready", 32'(bus.cmd_ready), 0);
    check("rst_rvalid", 32'(bus.rsp_valid), 0);
    check("rst_rlast", 32'(bus.rsp_last), 0);
    check("rst_rdata", 32'(bus.rsp_data), 0);
    check("rst_wdone", 32'(bus.wr_done), 0);
    check("rst_strb", 32'({ram_cs, ram_rd, ram_wr}), 0);
    check("rst_addr", 32'(ram_addr), 0);
    check("rst_din", 32'(ram_data_in), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("ready_after_rst", 32'(bus.cmd_ready), 1);

    // Write latency and strobe shape
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_wr    = 1'b1;
    bus.cmd_addr  = 16'h0005;
    bus.cmd_wdata = 16'h00AA;
    bus.cmd_len   = '0;
    check("w_ready_c0", 32'(bus.cmd_ready), 1);
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    ref_mem[5] = 16'h00AA;
    @(negedge clk);
    check("w_strb_c1", 32'({ram_cs, ram_wr, ram_rd}), 32'b110);
    check("w_addr_c1", 32'(ram_addr), 32'h0005);
    check("w_din_c1", 32'(ram_data_in), 32'h00AA);
    check("w_done_c1", 32'(bus.wr_done), 0);
    check("w_ready_c1", 32'(bus.cmd_ready), 0);
    @(negedge clk);
    check("w_done_c2", 32'(bus.wr_done), 1);
    check("w_strb_c2", 32'({ram_cs, ram_wr, ram_rd}), 0);
    check("w_ready_c2", 32'(bus.cmd_ready), 0);
    @(negedge clk);
    check("w_ready_c3", 32'(bus.cmd_ready), 1);
    check("w_done_c3", 32'(bus.wr_done), 0);

    // Fill and read back the whole model RAM
    for (int k = 0; k < MW; k++)
      send_cmd(1'b1, AW'(k), DW'((2 * k) % 256), '0);
    rr_mode = 0;
    for (int k = 0; k < MW; k++)
      send_cmd(1'b0, AW'(k), '0, '0);
    drain();

    // Held response under backpressure
    rr_mode = 2;
    @(posedge clk);
    @(posedge clk);
    send_cmd(1'b0, 16'h0007, '0, '0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("stall_valid_c3", 32'(bus.rsp_valid), 1);
    hold_d = bus.rsp_data;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid", 32'(bus.rsp_valid), 1);
      check("stall_data", 32'(bus.rsp_data), 32'(hold_d));
      check("stall_cs", 32'(ram_cs), 0);
    end
    rr_mode = 1;
    drain();

    // Wrapping burst (single beat when bursts are off)
    addr_log.delete();
    send_cmd(1'b0, 16'hFFFE, '0, 8'd3);
    drain();
    if (BURST) begin
      check("burst_n", 32'(addr_log.size()), 4);
      if (addr_log.size() == 4) begin
        check("burst_a0", 32'(addr_log[0]), 32'hFFFE);
        check("burst_a1", 32'(addr_log[1]), 32'hFFFF);
        check("burst_a2", 32'(addr_log[2]), 32'h0000);
        check("burst_a3", 32'(addr_log[3]), 32'h0001);
      end
    end else begin
      check("single_n", 32'(addr_log.size()), 1);
      if (addr_log.size() == 1)
        check("single_a0", 32'(addr_log[0]), 32'hFFFE);
    end

    // Reset during CAPTURE
    send_cmd(1'b0, 16'h0009, '0, '0);
    @(negedge clk);
    @(negedge clk);
    check("cap_strb", 32'({ram_cs, ram_rd}), 32'b11);
    #1 rst_n = 1'b0;
    #1;
    check("ar_strb", 32'({ram_cs, ram_rd, ram_wr}), 0);
    check("ar_ready", 32'(bus.cmd_ready), 0);
    check("ar_rvalid", 32'(bus.rsp_valid), 0);
    check("ar_rdata", 32'(bus.rsp_data), 0);
    check("ar_addr", 32'(ram_addr), 0);
    check("ar_wdone", 32'(bus.wr_done), 0);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("ar_ready_rel", 32'(bus.cmd_ready), 1);
    @(negedge clk);
    check("ar_no_stale", 32'(bus.rsp_valid), 0);

    // Back-to-back write then read, valid held high
    v = DW'($urandom);
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_wr    = 1'b1;
    bus.cmd_addr  = 16'h0123;
    bus.cmd_wdata = v;
    bus.cmd_len   = '0;
    check("b2b_ready0", 32'(bus.cmd_ready), 1);
    @(posedge clk);
    #1;
    ref_mem[16'h0123] = v;
    bus.cmd_wr = 1'b0;
    @(negedge clk);
    check("b2b_busy1", 32'(bus.cmd_ready), 0);
    @(negedge clk);
    check("b2b_busy2", 32'(bus.cmd_ready), 0);
    @(negedge clk);
    check("b2b_ready3", 32'(bus.cmd_ready), 1);
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    push_read(16'h0123, '0);
    drain();

    // Random mixed traffic
    rr_mode = 0;
    for (int i = 0; i < 300; i++)
      send_cmd(1'($urandom), AW'($urandom), DW'($urandom),
               LW'($urandom % 4));
    send_cmd(1'b0, AW'($urandom), '0, 8'hFF);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
